cache_ctrl_nway: RTL and testbench
==================================

# cache_ctrl_nway

Parametrised N-way set-associative, write-back/write-allocate cache controller for the mp2 cache. It sits between the CPU memory port and the physical-memory port, and owns the tag, valid, dirty and tree-PLRU metadata arrays. It drives way-select and load strobes to an external line-data array. It generalises the 2-way controller to WAYS ways, with parametrised set count and line size, plus hit/miss performance counters.

## Interface
- WAYS, 4: associativity; power of two, 2..8.
- S_INDEX, 3: set-index bits; 2**S_INDEX sets.
- S_OFFSET, 5: line-offset bits; TAG_W = 32 - S_INDEX - S_OFFSET.
- clk  in  1  clock; everything on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_addr  in  32  request address; held stable while the request is pending.
- cpu_read / cpu_write  in  1  request strobes; both high at once counts as no request.
- cpu_resp  out  1  one-cycle completion pulse.
- pmem_addr  out  32  line-aligned memory address.
- pmem_read / pmem_write  out  1  memory strobes; held until pmem_resp.
- pmem_resp  in  1  memory completion.
- way_sel  out  $clog2(WAYS)  way driven to the data array for read, fill or writeback.
- ld_line  out  1  data array loads pmem line into way_sel at cpu_addr's index.
- ld_cpu  out  1  data array merges the CPU write data into way_sel.
- hit_count / miss_count  out  32  saturating event counters.

## Operation
- Field split: index = cpu_addr[S_OFFSET+S_INDEX-1:S_OFFSET]; tag = cpu_addr[31:S_OFFSET+S_INDEX].
- Lookup is combinational against all ways. Hit requires valid and tag equal. More than one hit is impossible by construction.
- Victim choice: the lowest-numbered invalid way; if every way is valid, the PLRU victim.
- PLRU: WAYS-1 bits per set, heap-ordered with node 0 as root. Bit=0 sends the victim search to the lower half.
  - On every access to way w, each node on w's path is set to point away from w.
- States:
  - CHECK:
    - No request: stay.
    - Hit: assert cpu_resp and way_sel=hit way, update PLRU, hit_count++. On a write, also assert ld_cpu and set dirty. Go to DONE.
    - Miss, victim dirty: miss_count++, go to WRITEBACK.
    - Miss, victim clean: miss_count++, go to FILL.
  - WRITEBACK: pmem_write=1, way_sel=victim, pmem_addr={victim tag, index, 0}. On pmem_resp: clear victim dirty, go to FILL.
  - FILL: pmem_read=1, way_sel=victim, pmem_addr={tag, index, 0}. On pmem_resp: ld_line=1, store tag, valid=1, dirty=0, go to CHECK.
    - The re-lookup in CHECK then hits. It counts as a hit event too.
  - DONE: all strobes low for one cycle, go to CHECK. This prevents a double response while the CPU drops its strobe.
- The victim is latched on leaving CHECK, so way_sel is stable across WRITEBACK and FILL.
- Counters stop at 32'hFFFF_FFFF.

## Timing
- Reset: state=CHECK; all valid, dirty and PLRU bits 0; counters 0. cpu_resp, pmem_read, pmem_write, ld_line and ld_cpu are 0; way_sel=0; pmem_addr=0.
- Hit latency: cpu_resp in the first cycle the request is seen in CHECK. Sustained hit throughput is one per 2 cycles.
- Clean miss: the pmem_resp cycle, plus 1 cycle to CHECK, then the response.
- Dirty miss: writeback time + fill time + 1 cycle.
- pmem_read and pmem_write are never high together. pmem_addr is stable while either strobe is high.
- pmem_resp outside WRITEBACK or FILL is ignored.
- rst mid-transaction: strobes are low the next cycle, the pending memory transaction is abandoned, and all metadata is invalidated.
- A request withdrawn in CHECK before a miss is detected is not serviced. Once the FSM is in WRITEBACK or FILL, the sequence completes regardless.

## Structure
- cache_nway_pkg holds:
  - the state enum;
  - the TAG_W/index/offset width helper functions;
  - plru_update(bits, way) and plru_victim(bits) functions, parametrised by WAYS.
- One sub-module is natural: cache_plru_tree. It is a combinational per-set victim/update block, instantiated once on the indexed set.
- Metadata arrays are flop arrays inside cache_ctrl_nway.

## Test plan
All scenarios use WAYS=4, S_INDEX=3, S_OFFSET=5, and set 2 (address stride 0x100).
- After reset, read 0x40 → FILL with pmem_addr=0x40 and way_sel=0, then cpu_resp one cycle after pmem_resp. Final counters: hit=1, miss=1.
- Read 0x40, 0x140, 0x240, 0x340 → fills to ways 0, 1, 2, 3. Then read 0x440 → victim way 0 with no writeback, because way 0 is clean.
- Fill four ways, re-read 0x40, then read 0x440 → victim way 2 (PLRU), and 0x40 still hits.
- Write 0x40 → ld_cpu=1 and dirty set. Then force eviction of way 0 → WRITEBACK with pmem_addr=0x40 precedes FILL.
- Hold cpu_read=cpu_write=1 for 10 cycles → no strobes and no counter change. A back-to-back hit stream gives a cpu_resp every other cycle.
- Assert rst during FILL → pmem_read=0 the next cycle. The next read of 0x40 misses again.

Source files
------------

// File: rtl/cache_nway_pkg.sv
// Shared types and helpers for the N-way set-associative cache controller.
// PLRU helpers work on a max-width tree (8 ways) and are narrowed by the caller.
package cache_nway_pkg;
    localparam int PLRU_MAX  = 7;
    localparam int WAY_W_MAX = 3;

    typedef enum logic [1:0] {S_CHECK, S_WRITEBACK, S_FILL, S_DONE} state_t;

    function automatic int tag_w(input int s_index, input int s_offset);
        return 32 - s_index - s_offset;
    endfunction

    function automatic int num_sets(input int s_index);
        return 1 << s_index;
    endfunction

    function automatic int tree_levels(input int ways);
        int lg;
        lg = 0;
        for (int i = 1; i <= WAY_W_MAX; i++)
            if ((1 << i) <= ways) lg = i;
        return lg;
    endfunction

    // Each node on the accessed way's path is made to point away from it.
    function automatic logic [PLRU_MAX-1:0] plru_update(input logic [PLRU_MAX-1:0] bits,
                                                        input logic [WAY_W_MAX-1:0] way,
                                                        input int ways);
        logic [PLRU_MAX-1:0]  r;
        logic [WAY_W_MAX-1:0] w;
        logic [2:0]           node;
        r    = bits;
        node = '0;
        w    = way << (WAY_W_MAX - tree_levels(ways));
        for (int l = 0; l < WAY_W_MAX; l++) begin
            if (l < tree_levels(ways)) begin
                r[node] = ~w[WAY_W_MAX-1];
                node    = {node[1:0], 1'b0} + 3'd1 + {2'b00, w[WAY_W_MAX-1]};
                w       = w << 1;
            end
        end
        return r;
    endfunction

    function automatic logic [WAY_W_MAX-1:0] plru_victim(input logic [PLRU_MAX-1:0] bits,
                                                         input int ways);
        logic [WAY_W_MAX-1:0] v;
        logic [2:0]           node;
        v    = '0;
        node = '0;
        for (int l = 0; l < WAY_W_MAX; l++) begin
            if (l < tree_levels(ways)) begin
                v    = {v[WAY_W_MAX-2:0], bits[node]};
                node = {node[1:0], 1'b0} + 3'd1 + {2'b00, bits[node]};
            end
        end
        return v;
    endfunction
endpackage

// File: rtl/cache_plru_tree.sv
// Combinational tree-PLRU block for one set: victim selection and access update.
module cache_plru_tree
    import cache_nway_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         bits,
    input  logic [$clog2(WAYS)-1:0] way,
    output logic [$clog2(WAYS)-1:0] victim,
    output logic [WAYS-2:0]         bits_next
);
    localparam int WW = $clog2(WAYS);
    localparam int NB = WAYS - 1;

    assign victim    = WW'(plru_victim(PLRU_MAX'(bits), WAYS));
    assign bits_next = NB'(plru_update(PLRU_MAX'(bits), WAY_W_MAX'(way), WAYS));
endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way write-back/write-allocate cache controller: metadata arrays, lookup,
// miss sequencing to physical memory, and hit/miss counters.
module cache_ctrl_nway
    import cache_nway_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             cpu_addr,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    output logic                    cpu_resp,
    output logic [31:0]             pmem_addr,
    output logic                    pmem_read,
    output logic                    pmem_write,
    input  logic                    pmem_resp,
    output logic [$clog2(WAYS)-1:0] way_sel,
    output logic                    ld_line,
    output logic                    ld_cpu,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int TW   = tag_w(S_INDEX, S_OFFSET);
    localparam int SETS = num_sets(S_INDEX);
    localparam int WW   = $clog2(WAYS);

    state_t state, state_next;

    logic [TW-1:0]   tags  [SETS][WAYS];
    logic [WAYS-1:0] valid [SETS];
    logic [WAYS-1:0] dirty [SETS];
    logic [WAYS-2:0] plru  [SETS];
    logic [WW-1:0]   victim_q;

    logic [S_INDEX-1:0] idx;
    logic [TW-1:0]      tag;
    logic               req, is_write, hit, has_inv;
    logic [WW-1:0]      hit_way, inv_way, plru_vic, victim;
    logic [WAYS-2:0]    plru_upd;
    logic               hit_ev, miss_ev;
    logic               unused;

    assign idx      = cpu_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign tag      = cpu_addr[31:S_OFFSET+S_INDEX];
    assign unused   = ^cpu_addr[S_OFFSET-1:0];
    assign req      = cpu_read ^ cpu_write;
    assign is_write = cpu_write & ~cpu_read;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tags[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[idx][w]) begin
                has_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
    end

    cache_plru_tree #(.WAYS(WAYS)) u_plru (
        .bits      (plru[idx]),
        .way       (hit_way),
        .victim    (plru_vic),
        .bits_next (plru_upd)
    );

    assign victim  = has_inv ? inv_way : plru_vic;
    assign hit_ev  = (state == S_CHECK) && req && hit;
    assign miss_ev = (state == S_CHECK) && req && !hit;

    always_ff @(posedge clk) begin
        if (rst) state <= S_CHECK;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_CHECK:     if (req) state_next = hit ? S_DONE
                                             : (dirty[idx][victim] ? S_WRITEBACK : S_FILL);
            S_WRITEBACK: if (pmem_resp) state_next = S_FILL;
            S_FILL:      if (pmem_resp) state_next = S_CHECK;
            default:     state_next = S_CHECK;
        endcase
    end

    always_comb begin
        cpu_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        ld_line    = 1'b0;
        ld_cpu     = 1'b0;
        way_sel    = '0;
        pmem_addr  = '0;
        case (state)
            S_CHECK: if (hit_ev) begin
                cpu_resp = 1'b1;
                way_sel  = hit_way;
                ld_cpu   = is_write;
            end
            S_WRITEBACK: begin
                pmem_write = 1'b1;
                way_sel    = victim_q;
                pmem_addr  = {tags[idx][victim_q], idx, {S_OFFSET{1'b0}}};
            end
            S_FILL: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                pmem_addr = {tag, idx, {S_OFFSET{1'b0}}};
                ld_line   = pmem_resp;
            end
            default: ;
        endcase
    end

    // Victim is frozen on the miss so WRITEBACK and FILL target the same way.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s]  <= '0;
            end
            victim_q   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_ev) begin
                plru[idx] <= plru_upd;
                if (is_write) dirty[idx][hit_way] <= 1'b1;
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end
            if (miss_ev) begin
                victim_q <= victim;
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
            if (state == S_WRITEBACK && pmem_resp) dirty[idx][victim_q] <= 1'b0;
            if (state == S_FILL && pmem_resp) begin
                tags[idx][victim_q]  <= tag;
                valid[idx][victim_q] <= 1'b1;
                dirty[idx][victim_q] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Scenario bench for cache_ctrl_nway (4 ways, 8 sets, 32-byte lines, set 2).
module tb_cache_ctrl_nway;
    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic        cpu_resp;
    logic [31:0] pmem_addr;
    logic        pmem_read, pmem_write;
    logic        pmem_resp = 1'b0;
    logic [1:0]  way_sel;
    logic        ld_line, ld_cpu;
    logic [31:0] hit_count, miss_count;

    always #5 clk = ~clk;

    cache_ctrl_nway #(.WAYS(4), .S_INDEX(3), .S_OFFSET(5)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_resp(cpu_resp), .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .way_sel(way_sel), .ld_line(ld_line), .ld_cpu(ld_cpu),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct packed { logic wr; logic [31:0] addr; logic [1:0] way; } txn_t;
    txn_t exp_q[$];
    txn_t obs_q[$];

    int checks = 0, passes = 0;
    int r_lat, r_ld_line, r_both;
    logic [1:0] r_way;
    logic r_ld_cpu;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0; pmem_resp = 1'b0;
        #1;
    endtask

    // Drives one request, acts as a fixed-latency memory, logs memory transactions.
    task automatic access(input logic [31:0] a, input logic wr);
        int  cnt;
        bit  logged, done;
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        cpu_addr = a; cpu_read = !wr; cpu_write = wr;
        cnt = 0; logged = 0; done = 0; r_ld_line = 0; r_lat = -1;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (cpu_resp) begin
                done = 1; r_lat = c; r_way = way_sel; r_ld_cpu = ld_cpu;
            end else begin
                if (pmem_read && pmem_write) r_both++;
                if (pmem_read || pmem_write) begin
                    if (!logged) begin
                        obs_q.push_back(txn_t'{pmem_write, pmem_addr, way_sel});
                        logged = 1;
                    end
                    cnt++;
                    if (cnt == MEM_LAT) begin
                        pmem_resp = 1'b1;
                        #1;
                        if (pmem_read && ld_line) r_ld_line++;
                        cnt = 0; logged = 0;
                    end
                end
                @(negedge clk);
                pmem_resp = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL access_timeout addr=%h got no cpu_resp, required one within 200 cycles", a);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        @(negedge clk); #1;
        checks++; if (cpu_resp !== 1'b0)   $display("FAIL rst_cpu_resp got=%b exp=0", cpu_resp);     else passes++;
        checks++; if (pmem_read !== 1'b0)  $display("FAIL rst_pmem_read got=%b exp=0", pmem_read);   else passes++;
        checks++; if (pmem_write !== 1'b0) $display("FAIL rst_pmem_write got=%b exp=0", pmem_write); else passes++;
        checks++; if (ld_line !== 1'b0)    $display("FAIL rst_ld_line got=%b exp=0", ld_line);       else passes++;
        checks++; if (ld_cpu !== 1'b0)     $display("FAIL rst_ld_cpu got=%b exp=0", ld_cpu);         else passes++;
        checks++; if (way_sel !== 2'd0)    $display("FAIL rst_way_sel got=%0d exp=0", way_sel);      else passes++;
        checks++; if (pmem_addr !== 32'h0) $display("FAIL rst_pmem_addr got=%h exp=0", pmem_addr);   else passes++;
        checks++; if (hit_count !== 32'h0) $display("FAIL rst_hit_count got=%0d exp=0", hit_count);  else passes++;
        checks++; if (miss_count !== 32'h0) $display("FAIL rst_miss_count got=%0d exp=0", miss_count); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_clean_miss();
        txn_t e, o;
        do_reset();
        exp_q.push_back(txn_t'{1'b0, 32'h40, 2'd0});
        access(32'h40, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) $display("FAIL cm_txn got=none exp=%h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL cm_txn got=%h exp=%h", o, e); else passes++; end
        end
        checks++; if (obs_q.size() != 0) $display("FAIL cm_extra_txn got=%0d exp=0", obs_q.size()); else passes++;
        obs_q.delete();
        checks++; if (r_lat != 4)      $display("FAIL cm_latency got=%0d exp=4", r_lat);        else passes++;
        checks++; if (r_ld_line != 1)  $display("FAIL cm_ld_line got=%0d exp=1", r_ld_line);    else passes++;
        checks++; if (r_way !== 2'd0)  $display("FAIL cm_resp_way got=%0d exp=0", r_way);       else passes++;
        checks++; if (r_ld_cpu !== 1'b0) $display("FAIL cm_ld_cpu got=%b exp=0", r_ld_cpu);     else passes++;
        checks++; if (hit_count !== 32'd1)  $display("FAIL cm_hits got=%0d exp=1", hit_count);  else passes++;
        checks++; if (miss_count !== 32'd1) $display("FAIL cm_misses got=%0d exp=1", miss_count); else passes++;
    endtask

    task automatic test_fill_ways();
        txn_t e, o;
        do_reset();
        for (int i = 0; i < 5; i++)
            exp_q.push_back(txn_t'{1'b0, 32'h40 + 32'(i) * 32'h100, 2'(i % 4)});
        for (int i = 0; i < 5; i++) access(32'h40 + 32'(i) * 32'h100, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) $display("FAIL fw_txn got=none exp=%h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL fw_txn got=%h exp=%h", o, e); else passes++; end
        end
        checks++; if (obs_q.size() != 0) $display("FAIL fw_extra_txn got=%0d exp=0", obs_q.size()); else passes++;
        obs_q.delete();
        checks++; if (r_lat != 4) $display("FAIL fw_clean_evict_latency got=%0d exp=4", r_lat); else passes++;
        checks++; if (hit_count !== 32'd5)  $display("FAIL fw_hits got=%0d exp=5", hit_count);   else passes++;
        checks++; if (miss_count !== 32'd5) $display("FAIL fw_misses got=%0d exp=5", miss_count); else passes++;
    endtask

    task automatic test_plru();
        txn_t e, o;
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(txn_t'{1'b0, 32'h40 + 32'(i) * 32'h100, 2'(i)});
        exp_q.push_back(txn_t'{1'b0, 32'h440, 2'd2});
        for (int i = 0; i < 4; i++) access(32'h40 + 32'(i) * 32'h100, 1'b0);
        access(32'h40, 1'b0);
        checks++; if (r_lat != 0) $display("FAIL plru_rehit_latency got=%0d exp=0", r_lat); else passes++;
        access(32'h440, 1'b0);
        checks++; if (r_way !== 2'd2) $display("FAIL plru_fill_way got=%0d exp=2", r_way); else passes++;
        access(32'h40, 1'b0);
        checks++; if (r_lat != 0)     $display("FAIL plru_keep_latency got=%0d exp=0", r_lat); else passes++;
        checks++; if (r_way !== 2'd0) $display("FAIL plru_keep_way got=%0d exp=0", r_way);     else passes++;
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) $display("FAIL plru_txn got=none exp=%h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL plru_txn got=%h exp=%h", o, e); else passes++; end
        end
        checks++; if (obs_q.size() != 0) $display("FAIL plru_extra_txn got=%0d exp=0", obs_q.size()); else passes++;
        obs_q.delete();
    endtask

    task automatic test_writeback();
        txn_t e, o;
        do_reset();
        exp_q.push_back(txn_t'{1'b0, 32'h40, 2'd0});
        access(32'h40, 1'b1);
        checks++; if (r_ld_cpu !== 1'b1) $display("FAIL wb_ld_cpu got=%b exp=1", r_ld_cpu); else passes++;
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back(txn_t'{1'b0, 32'h40 + 32'(i) * 32'h100, 2'(i)});
            access(32'h40 + 32'(i) * 32'h100, 1'b0);
        end
        exp_q.push_back(txn_t'{1'b1, 32'h40, 2'd0});
        exp_q.push_back(txn_t'{1'b0, 32'h440, 2'd0});
        access(32'h440, 1'b0);
        checks++; if (r_lat != 7) $display("FAIL wb_dirty_latency got=%0d exp=7", r_lat); else passes++;
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) $display("FAIL wb_txn got=none exp=%h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL wb_txn got=%h exp=%h", o, e); else passes++; end
        end
        checks++; if (obs_q.size() != 0) $display("FAIL wb_extra_txn got=%0d exp=0", obs_q.size()); else passes++;
        obs_q.delete();
        checks++; if (r_both != 0) $display("FAIL strobes_exclusive got=%0d exp=0", r_both); else passes++;
    endtask

    task automatic test_no_request();
        int viol;
        do_reset();
        access(32'h40, 1'b0);
        obs_q.delete();
        idle();
        viol = 0;
        cpu_addr = 32'h140; cpu_read = 1'b1; cpu_write = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (cpu_resp || pmem_read || pmem_write || ld_line || ld_cpu) viol++;
        end
        idle();
        checks++; if (viol != 0) $display("FAIL noreq_strobes got=%0d exp=0", viol); else passes++;
        checks++; if (hit_count !== 32'd1)  $display("FAIL noreq_hits got=%0d exp=1", hit_count);    else passes++;
        checks++; if (miss_count !== 32'd1) $display("FAIL noreq_misses got=%0d exp=1", miss_count); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] pat;
        idle();
        cpu_addr = 32'h40; cpu_read = 1'b1; cpu_write = 1'b0; pat = '0;
        for (int c = 0; c < 10; c++) begin
            #1; pat[c] = cpu_resp;
            @(negedge clk);
        end
        cpu_read = 1'b0;
        idle();
        checks++; if (pat !== 10'b0101010101) $display("FAIL b2b_pattern got=%b exp=0101010101", pat); else passes++;
        checks++; if (hit_count !== 32'd6)  $display("FAIL b2b_hits got=%0d exp=6", hit_count);    else passes++;
        checks++; if (miss_count !== 32'd1) $display("FAIL b2b_misses got=%0d exp=1", miss_count); else passes++;
    endtask

    task automatic test_rst_mid_fill();
        txn_t e, o;
        bit seen;
        do_reset();
        @(negedge clk);
        cpu_addr = 32'h40; cpu_read = 1'b1; cpu_write = 1'b0; pmem_resp = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (pmem_read) seen = 1;
            else @(negedge clk);
        end
        checks++; if (!seen) $display("FAIL rmf_fill_start got=0 exp=1"); else passes++;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (pmem_read !== 1'b0)  $display("FAIL rmf_pmem_read got=%b exp=0", pmem_read);   else passes++;
        checks++; if (pmem_write !== 1'b0) $display("FAIL rmf_pmem_write got=%b exp=0", pmem_write); else passes++;
        rst = 1'b0; cpu_read = 1'b0;
        exp_q.push_back(txn_t'{1'b0, 32'h40, 2'd0});
        access(32'h40, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) $display("FAIL rmf_txn got=none exp=%h", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL rmf_txn got=%h exp=%h", o, e); else passes++; end
        end
        checks++; if (obs_q.size() != 0) $display("FAIL rmf_extra_txn got=%0d exp=0", obs_q.size()); else passes++;
        obs_q.delete();
        checks++; if (r_lat != 4) $display("FAIL rmf_latency got=%0d exp=4", r_lat); else passes++;
        checks++; if (miss_count !== 32'd1) $display("FAIL rmf_misses got=%0d exp=1", miss_count); else passes++;
    endtask

    initial begin
        r_both = 0;
        test_reset();
        test_clean_miss();
        test_fill_ways();
        test_plru();
        test_writeback();
        test_no_request();
        test_back_to_back();
        test_rst_mid_fill();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
